// File: rtl/viewport_pixel_pipe.sv
// viewport_pixel_pipe
//   Consumes per-pixel sprite/area/background ROM indices for the game
//   viewport, presents them to three external synchronous ROMs, waits out the
//   ROM read latency, resolves layer priority/transparency and emits one
//   palette selection per pixel. Also accumulates pixel-exact Kirby/area
//   overlap per frame and reports it at each frame boundary.
//
// Ports
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   DrawX, DrawY                 current scan coordinate
//   Kirby_Pos_X/Y                sprite offset inside the viewport
//   Image_width/height           sprite frame size
//   kirbyindex/areaindex/backindex   ROM indices for this scan coordinate
//   Kirby_addr/Area_addr/Back_addr   registered ROM addresses
//   Kirby_data/Area_data/Back_data   ROM read data (ROM_LAT cycles later)
//   Pix_X, Pix_Y, Pix_inwin      delayed coordinate and in-window flag
//   Pix_layer, Pix_cidx          0 none, 1 back, 2 area, 3 Kirby; palette idx
//   Collide, Collide_cnt         previous frame overlap flag / pixel count
//   Frame_tick                   one-cycle pulse when Collide* update
module viewport_pixel_pipe #(
    parameter int ROM_LAT = 2,
    parameter int WIN_X0  = 203,
    parameter int WIN_Y0  = 152,
    parameter int WIN_W   = 233,
    parameter int WIN_H   = 176,
    parameter int KEY_IDX = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [7:0]  Kirby_Pos_X,
    input  logic [7:0]  Kirby_Pos_Y,
    input  logic [7:0]  Image_width,
    input  logic [6:0]  Image_height,
    input  logic [17:0] kirbyindex,
    input  logic [17:0] areaindex,
    input  logic [16:0] backindex,
    output logic [17:0] Kirby_addr,
    output logic [17:0] Area_addr,
    output logic [16:0] Back_addr,
    input  logic [4:0]  Kirby_data,
    input  logic [3:0]  Area_data,
    input  logic [3:0]  Back_data,
    output logic [9:0]  Pix_X,
    output logic [9:0]  Pix_Y,
    output logic        Pix_inwin,
    output logic [1:0]  Pix_layer,
    output logic [4:0]  Pix_cidx,
    output logic        Collide,
    output logic [15:0] Collide_cnt,
    output logic        Frame_tick
);

    // Packet travelling alongside the ROM read: {x[9:0], y[9:0], inwin, hit}
    localparam int PKT_W = 22;

    // ---------------- Stage A: window / sprite-rectangle test ----------------
    // All comparisons at 11 bits so WIN_X0 + offset + width never wraps.
    logic [10:0] x11, y11, spr_x0, spr_y0, spr_x1, spr_y1;
    logic        in_win, spr_hit;

    assign x11    = {1'b0, DrawX};
    assign y11    = {1'b0, DrawY};
    assign spr_x0 = 11'(WIN_X0) + {3'b000, Kirby_Pos_X};
    assign spr_y0 = 11'(WIN_Y0) + {3'b000, Kirby_Pos_Y};
    assign spr_x1 = spr_x0 + {3'b000, Image_width};
    assign spr_y1 = spr_y0 + {4'b0000, Image_height};

    assign in_win  = (x11 >= 11'(WIN_X0)) && (x11 < 11'(WIN_X0 + WIN_W)) &&
                     (y11 >= 11'(WIN_Y0)) && (y11 < 11'(WIN_Y0 + WIN_H));
    assign spr_hit = in_win && (x11 >= spr_x0) && (x11 < spr_x1) &&
                     (y11 >= spr_y0) && (y11 < spr_y1);

    logic [PKT_W-1:0] a_pkt_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Kirby_addr <= '0;
            Area_addr  <= '0;
            Back_addr  <= '0;
            a_pkt_reg  <= '0;
        end else begin
            Kirby_addr <= kirbyindex;
            Area_addr  <= areaindex;
            Back_addr  <= backindex;
            a_pkt_reg  <= {DrawX, DrawY, in_win, spr_hit};
        end
    end

    // ---------------- Delay line: ROM_LAT stages -----------------------------
    // The last stage lines up with the ROM data for the same pixel.
    logic [PKT_W-1:0] dly_reg [ROM_LAT];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) dly_reg[i] <= '0;
        end else begin
            dly_reg[0] <= a_pkt_reg;
            for (int i = 1; i < ROM_LAT; i++) dly_reg[i] <= dly_reg[i-1];
        end
    end

    logic [PKT_W-1:0] tail;
    logic [9:0]       t_x, t_y;
    logic             t_in, t_hit;

    assign tail  = dly_reg[ROM_LAT-1];
    assign t_x   = tail[21:12];
    assign t_y   = tail[11:2];
    assign t_in  = tail[1];
    assign t_hit = tail[0];

    // ---------------- Stage C: priority / transparency -----------------------
    logic       kirby_opq, area_opq, overlap, boundary;
    logic [1:0] layer_next;
    logic [4:0] cidx_next;

    assign kirby_opq = t_hit && (Kirby_data != 5'(KEY_IDX));
    assign area_opq  = t_in  && (Area_data  != 4'(KEY_IDX));
    assign overlap   = kirby_opq && area_opq;
    assign boundary  = (t_x == 10'd0) && (t_y == 10'd0);

    always_comb begin
        layer_next = 2'd0;
        cidx_next  = 5'd0;
        if (kirby_opq) begin
            layer_next = 2'd3;
            cidx_next  = Kirby_data;
        end else if (area_opq) begin
            layer_next = 2'd2;
            cidx_next  = {1'b0, Area_data};
        end else if (t_in) begin
            layer_next = 2'd1;
            cidx_next  = {1'b0, Back_data};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pix_X     <= '0;
            Pix_Y     <= '0;
            Pix_inwin <= 1'b0;
            Pix_layer <= '0;
            Pix_cidx  <= '0;
        end else begin
            Pix_X     <= t_x;
            Pix_Y     <= t_y;
            Pix_inwin <= t_in;
            Pix_layer <= layer_next;
            Pix_cidx  <= cidx_next;
        end
    end

    // ---------------- Collision accumulation ---------------------------------
    // armed_reg blocks a second tick while the scan sits on (0,0). It starts
    // cleared so the all-zero contents of a freshly reset pipeline are not
    // mistaken for a frame boundary.
    logic        pend_flag_reg;
    logic [15:0] pend_cnt_reg;
    logic        armed_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_flag_reg <= 1'b0;
            pend_cnt_reg  <= '0;
            armed_reg     <= 1'b0;
            Collide       <= 1'b0;
            Collide_cnt   <= '0;
            Frame_tick    <= 1'b0;
        end else begin
            Frame_tick <= 1'b0;
            if (boundary) begin
                // (0,0) is outside the viewport, so no overlap can coincide.
                if (armed_reg) begin
                    Collide       <= pend_flag_reg;
                    Collide_cnt   <= pend_cnt_reg;
                    Frame_tick    <= 1'b1;
                    pend_flag_reg <= 1'b0;
                    pend_cnt_reg  <= '0;
                    armed_reg     <= 1'b0;
                end
            end else begin
                armed_reg <= 1'b1;
                if (overlap) begin
                    pend_flag_reg <= 1'b1;
                    if (pend_cnt_reg != 16'hFFFF)
                        pend_cnt_reg <= pend_cnt_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viewport_pixel_pipe.sv
// Directed testbench for viewport_pixel_pipe. Models the three external
// synchronous ROMs as ROM_LAT-deep register chains whose read data equals the
// low bits of the address, so each index chosen by a vector doubles as the
// colour index the ROM returns.
module tb_viewport_pixel_pipe;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic [7:0]  Kirby_Pos_X, Kirby_Pos_Y, Image_width;
    logic [6:0]  Image_height;
    logic [17:0] kirbyindex, areaindex;
    logic [16:0] backindex;
    logic [17:0] Kirby_addr, Area_addr;
    logic [16:0] Back_addr;
    logic [4:0]  Kirby_data;
    logic [3:0]  Area_data, Back_data;
    logic [9:0]  Pix_X, Pix_Y;
    logic        Pix_inwin;
    logic [1:0]  Pix_layer;
    logic [4:0]  Pix_cidx;
    logic        Collide;
    logic [15:0] Collide_cnt;
    logic        Frame_tick;

    // Second instance, ROM_LAT=4, used for the latency check only
    logic [17:0] u4_kaddr, u4_aaddr;
    logic [16:0] u4_baddr;
    logic [9:0]  u4_pix_x, u4_pix_y;
    logic        u4_inwin, u4_collide, u4_tick;
    logic [1:0]  u4_layer;
    logic [4:0]  u4_cidx;
    logic [15:0] u4_cnt;
    logic [4:0]  zero5 = '0;
    logic [3:0]  zero4 = '0;

    always #5 Clk = ~Clk;

    // ROM models (ROM_LAT=2)
    logic [4:0] k_q1 = '0, k_q2 = '0;
    logic [3:0] a_q1 = '0, a_q2 = '0, b_q1 = '0, b_q2 = '0;
    always @(posedge Clk) begin
        k_q1 <= Kirby_addr[4:0];
        k_q2 <= k_q1;
        a_q1 <= Area_addr[3:0];
        a_q2 <= a_q1;
        b_q1 <= Back_addr[3:0];
        b_q2 <= b_q1;
    end
    assign Kirby_data = k_q2;
    assign Area_data  = a_q2;
    assign Back_data  = b_q2;

    viewport_pixel_pipe #(.ROM_LAT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .Kirby_Pos_X(Kirby_Pos_X), .Kirby_Pos_Y(Kirby_Pos_Y),
        .Image_width(Image_width), .Image_height(Image_height),
        .kirbyindex(kirbyindex), .areaindex(areaindex), .backindex(backindex),
        .Kirby_addr(Kirby_addr), .Area_addr(Area_addr), .Back_addr(Back_addr),
        .Kirby_data(Kirby_data), .Area_data(Area_data), .Back_data(Back_data),
        .Pix_X(Pix_X), .Pix_Y(Pix_Y), .Pix_inwin(Pix_inwin),
        .Pix_layer(Pix_layer), .Pix_cidx(Pix_cidx), .Collide(Collide),
        .Collide_cnt(Collide_cnt), .Frame_tick(Frame_tick)
    );

    viewport_pixel_pipe #(.ROM_LAT(4)) u4 (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .Kirby_Pos_X(Kirby_Pos_X), .Kirby_Pos_Y(Kirby_Pos_Y),
        .Image_width(Image_width), .Image_height(Image_height),
        .kirbyindex(kirbyindex), .areaindex(areaindex), .backindex(backindex),
        .Kirby_addr(u4_kaddr), .Area_addr(u4_aaddr), .Back_addr(u4_baddr),
        .Kirby_data(zero5), .Area_data(zero4), .Back_data(zero4),
        .Pix_X(u4_pix_x), .Pix_Y(u4_pix_y), .Pix_inwin(u4_inwin),
        .Pix_layer(u4_layer), .Pix_cidx(u4_cidx), .Collide(u4_collide),
        .Collide_cnt(u4_cnt), .Frame_tick(u4_tick)
    );

    int total = 0;
    int bad   = 0;
    int tick_n;
    logic        tick_col;
    logic [15:0] tick_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one scan pixel for one cycle; records any Frame_tick seen.
    task automatic cyc(input int x, input int y, input int k, input int a, input int b);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        kirbyindex = 18'h2A000 | 18'(k);
        areaindex  = 18'h15000 | 18'(a);
        backindex  = 17'h0B000 | 17'(b);
        @(posedge Clk);
        #1;
        if (Frame_tick) begin
            tick_n++;
            tick_col = Collide;
            tick_cnt = Collide_cnt;
        end
    endtask

    task automatic clr_ticks();
        tick_n   = 0;
        tick_col = 1'bx;
        tick_cnt = 'x;
    endtask

    typedef struct {
        int x, y, k, a, b, inwin, layer, cidx;
    } vec_t;
    vec_t vt[10];

    initial begin
        // x, y, kirby, area, back -> inwin, layer, cidx (sprite at 213..228 x 172..187)
        vt[0] = '{202, 152, 0, 0, 7, 0, 0, 0};
        vt[1] = '{203, 152, 0, 0, 7, 1, 1, 7};
        vt[2] = '{435, 152, 0, 0, 7, 1, 1, 7};
        vt[3] = '{436, 152, 0, 0, 7, 0, 0, 0};
        vt[4] = '{213, 172, 0, 3, 7, 1, 2, 3};
        vt[5] = '{214, 172, 9, 3, 7, 1, 3, 9};
        vt[6] = '{212, 172, 4, 0, 5, 1, 1, 5};
        vt[7] = '{229, 172, 4, 0, 5, 1, 1, 5};
        vt[8] = '{228, 187, 4, 0, 5, 1, 3, 4};
        vt[9] = '{228, 188, 4, 0, 5, 1, 1, 5};

        Reset_n      = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        kirbyindex   = '0;
        areaindex    = '0;
        backindex    = '0;
        Kirby_Pos_X  = 8'd10;
        Kirby_Pos_Y  = 8'd20;
        Image_width  = 8'd16;
        Image_height = 7'd16;
        clr_ticks();

        // Reset held: everything stays zero regardless of inputs
        for (int c = 0; c < 4; c++) begin
            cyc(c + 250, 200, 9, 3, 7);
            chk("rst_pix_x", 32'(Pix_X), 0);
            chk("rst_layer", 32'(Pix_layer), 0);
            chk("rst_kaddr", 32'(Kirby_addr), 0);
            chk("rst_cnt", 32'(Collide_cnt), 0);
            chk("rst_tick", 32'(Frame_tick), 0);
        end
        $display("reset phase checked");

        // Release and sweep: 4-cycle latency (ROM_LAT=2), 6-cycle (ROM_LAT=4)
        Reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc(c, 5, 0, 0, 0);
            chk("lat2_x", 32'(Pix_X), (c >= 3) ? c - 3 : 0);
            chk("lat2_y", 32'(Pix_Y), (c >= 3) ? 5 : 0);
            chk("lat4_x", 32'(u4_pix_x), (c >= 5) ? c - 5 : 0);
            $display("sweep c=%0d pix_x=%0d u4_pix_x=%0d", c, Pix_X, u4_pix_x);
        end

        // Directed pixel vectors
        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].x, vt[i].y, vt[i].k, vt[i].a, vt[i].b);
            chk("kaddr", 32'(Kirby_addr), 32'(18'h2A000 | 18'(vt[i].k)));
            chk("aaddr", 32'(Area_addr), 32'(18'h15000 | 18'(vt[i].a)));
            chk("baddr", 32'(Back_addr), 32'(17'h0B000 | 17'(vt[i].b)));
            for (int f = 0; f < 3; f++) cyc(1, 1, 0, 0, 0);
            chk("vec_x", 32'(Pix_X), vt[i].x);
            chk("vec_y", 32'(Pix_Y), vt[i].y);
            chk("vec_inwin", 32'(Pix_inwin), vt[i].inwin);
            chk("vec_layer", 32'(Pix_layer), vt[i].layer);
            chk("vec_cidx", 32'(Pix_cidx), vt[i].cidx);
            $display("vec %0d (%0d,%0d) inwin=%0d layer=%0d cidx=%0d", i,
                     Pix_X, Pix_Y, Pix_inwin, Pix_layer, Pix_cidx);
        end

        // Flush to a clean frame start
        cyc(0, 0, 0, 0, 0);
        for (int f = 0; f < 6; f++) cyc(1, 1, 0, 0, 0);

        // Frame N: 37 overlap pixels, then a 3-cycle stall on (0,0)
        clr_ticks();
        for (int i = 0; i < 37; i++) cyc(213 + i % 16, 172 + i / 16, 9, 3, 0);
        for (int i = 0; i < 2; i++) cyc(300, 200, 0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        chk("fN_ticks", 32'(tick_n), 1);
        chk("fN_collide", 32'(tick_col), 1);
        chk("fN_cnt", 32'(tick_cnt), 37);
        chk("fN_cnt_hold", 32'(Collide_cnt), 37);
        $display("frame N ticks=%0d collide=%0d cnt=%0d", tick_n, tick_col, tick_cnt);

        // Frame N+1: no overlap
        clr_ticks();
        for (int i = 0; i < 5; i++) cyc(300, 200, 0, 3, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        chk("fN1_ticks", 32'(tick_n), 1);
        chk("fN1_collide", 32'(tick_col), 0);
        chk("fN1_cnt", 32'(tick_cnt), 0);
        $display("frame N+1 ticks=%0d collide=%0d cnt=%0d", tick_n, tick_col, tick_cnt);

        // Reset mid-frame after 10 overlaps discards pending state
        for (int i = 0; i < 10; i++) cyc(213 + i, 180, 9, 3, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        Reset_n = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("mid_rst_collide", 32'(Collide), 0);
        chk("mid_rst_tick", 32'(Frame_tick), 0);
        Reset_n = 1'b1;
        clr_ticks();
        for (int i = 0; i < 3; i++) cyc(300, 200, 0, 3, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        chk("post_rst_ticks", 32'(tick_n), 1);
        chk("post_rst_collide", 32'(tick_col), 0);
        chk("post_rst_cnt", 32'(tick_cnt), 0);
        $display("post-reset frame ticks=%0d collide=%0d cnt=%0d", tick_n, tick_col, tick_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
